spi_frame_ctrl: RTL
===================

Name: spi_frame_ctrl

Overview:
- Frame-level controller placed directly upstream of the SPI master core.
- Buffers host TX bytes in a small FIFO and drives the core's byte handshake.
- Owns the active-low slave select, including setup and hold gaps, and returns received bytes to the host through a valid/ready port.
- One frame = i_len bytes transferred with SS held low for the whole frame.

Parameters:
- DATA_WIDTH, 8, byte width; must match the SPI core.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
- LEN_WIDTH, 8, width of the frame byte count.
- SS_SETUP_CYC, 4, clk cycles from SS falling to the first byte offered; minimum 1.
- SS_HOLD_CYC, 4, clk cycles from the last byte done to SS rising; minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_tx_data  in  DATA_WIDTH  host byte to send
- i_tx_valid  in  1  host byte valid
- o_tx_ready  out  1  FIFO not full
- i_start  in  1  start-frame pulse; sampled only in IDLE
- i_len  in  LEN_WIDTH  frame byte count; captured on start; 0 = no-op
- o_busy  out  1  high in every state except IDLE
- o_ss_n  out  1  slave select, active low
- o_spi_data  out  DATA_WIDTH  byte to the core (FIFO head)
- o_spi_valid  out  1  byte offered to the core
- i_spi_ready  in  1  core accepts the offered byte this cycle
- i_spi_done  in  1  one-cycle pulse: core finished a byte
- i_spi_rx_data  in  DATA_WIDTH  core's received byte, valid with i_spi_done
- o_rx_data  out  DATA_WIDTH  received byte to the host
- o_rx_valid  out  1  received byte valid
- i_rx_ready  in  1  host accepts the received byte
- o_frame_done  out  1  one-cycle pulse when SS deasserts

Behaviour:
- Reset values: o_ss_n=1, o_busy=0, o_spi_valid=0, o_rx_valid=0, o_rx_data=0, o_frame_done=0, FIFO empty (o_tx_ready=1), state IDLE. A reset mid-frame aborts immediately: SS rises on the next edge and FIFO contents are discarded.
- FIFO write: when i_tx_valid && o_tx_ready. Writes are allowed in any state.
- FIFO read: when o_spi_valid && i_spi_ready.
  - A simultaneous read and write when full is allowed (count unchanged).
  - A simultaneous read and write when empty writes only; there is no fall-through.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Register-map style state machine (states in spi_pkg):
  - IDLE: on i_start with i_len!=0, capture len_rem=i_len, drive o_ss_n=0, load timer=SS_SETUP_CYC-1, go to SETUP. An i_start with i_len==0 is ignored; no frame_done.
  - SETUP: decrement timer; when timer==0, go to XFER.
  - XFER:
    - o_spi_valid = FIFO not empty && issued<len.
    - On i_spi_done: len_rem decrements.
    - When len_rem reaches 0 on a done, load timer=SS_HOLD_CYC-1 and go to HOLD.
    - An empty FIFO simply stalls XFER; SS stays low.
  - HOLD: decrement timer; when timer==0, set o_ss_n=1 and pulse o_frame_done, go to IDLE.
- Issued count:
  - Tracked separately from the done count; never offer more than i_len bytes.
  - Extra FIFO bytes remain queued for the next frame.
- RX path:
  - On i_spi_done, o_rx_data<=i_spi_rx_data and o_rx_valid<=1.
  - o_rx_valid clears on i_rx_ready. A done in the same cycle as the ready keeps valid=1 with the new data.
  - With no overrun feature, new data overwrites unaccepted data.
- i_spi_done outside XFER: ignored by the state machine; still captured by the RX path.
- i_start while busy: ignored.

Optional Feature:
- SPI_RX_OVERRUN_EN:
  - Adds output o_rx_overrun (1 bit, reset 0).
  - Sticky set when i_spi_done arrives while o_rx_valid=1 and i_rx_ready=0.
  - Cleared only on the next i_start accepted in IDLE.
  - The data is still overwritten.
- Without the macro: the port is absent and no overrun logic is built.

Decomposition:
- spi_pkg: frame_state_t enum (IDLE, SETUP, XFER, HOLD), and a localparam helper function clog2_safe for pointer widths.
- Sub-module spi_sync_fifo:
  - Parameters DATA_WIDTH and DEPTH.
  - Ports: wr_en/wr_data/full, rd_en/rd_data/empty, count.
  - Combinational read of the head.

Test Plan:
- Basic frame: preload 3 bytes 0xA5,0x3C,0xFF; start len=3; model core ready after 2 cycles, done 16 cycles later.
  - o_ss_n low exactly SS_SETUP_CYC cycles before the first valid.
  - 3 rx bytes delivered.
  - SS high SS_HOLD_CYC cycles after the 3rd done.
  - One o_frame_done pulse.
- Stall: start len=2 with an empty FIFO; write a byte 20 cycles later.
  - SS low throughout; o_spi_valid stays 0 until the write.
  - Frame completes after the 2nd byte.
- Overfill: write 10 bytes with FIFO_DEPTH=8.
  - o_tx_ready drops after the 8th; bytes 9 and 10 accepted only after core reads.
  - Order preserved.
- Length bound: FIFO holds 5, start len=2.
  - Exactly 2 core handshakes; count=3 remains after frame_done.
  - The next frame sends bytes 3..5.
- Reset mid-XFER (after 1 of 4 bytes): next cycle o_ss_n=1, o_busy=0, o_tx_ready=1, o_rx_valid=0.
- With SPI_RX_OVERRUN_EN: hold i_rx_ready=0 over 2 dones.
  - o_rx_overrun=1 and o_rx_data is the 2nd byte.
  - The next start clears o_rx_overrun.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame controller slice.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} frame_state_t;

  // Bits needed to index n entries, never less than 1.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with a combinational head read; used as the TX byte buffer.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int PTR_W      = clog2_safe(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [PTR_W:0]        count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // A read frees a slot in the same cycle, so a full FIFO may take a write alongside it.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame controller in front of the SPI master core: TX FIFO, slave select timing, RX return.
// Define SPI_RX_OVERRUN_EN to add the sticky o_rx_overrun flag.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int LEN_WIDTH    = 8,
  parameter int SS_SETUP_CYC = 4,
  parameter int SS_HOLD_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_ss_n,
  output logic [DATA_WIDTH-1:0] o_spi_data,
  output logic                  o_spi_valid,
  input  logic                  i_spi_ready,
  input  logic                  i_spi_done,
  input  logic [DATA_WIDTH-1:0] i_spi_rx_data,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_frame_done
`ifdef SPI_RX_OVERRUN_EN
  ,
  output logic                  o_rx_overrun
`endif
);

  localparam int PTR_W = clog2_safe(FIFO_DEPTH);
  localparam int TMR_W = clog2_safe((SS_SETUP_CYC > SS_HOLD_CYC) ? SS_SETUP_CYC : SS_HOLD_CYC);

  frame_state_t         state, state_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic [LEN_WIDTH-1:0] len_rem, len_rem_nxt;
  logic [LEN_WIDTH-1:0] len_cap, issued;
  logic                 start_ok, frame_done_q;
  logic                 fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [PTR_W:0]       fifo_cnt_unused;

  assign fifo_wr = i_tx_valid && o_tx_ready;
  assign fifo_rd = o_spi_valid && i_spi_ready;

  spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (i_tx_data),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (o_spi_data),
    .empty   (fifo_empty),
    .count   (fifo_cnt_unused)
  );

  assign start_ok     = (state == IDLE) && i_start && (i_len != '0);
  assign o_tx_ready   = !fifo_full;
  assign o_busy       = (state != IDLE);
  assign o_ss_n       = (state == IDLE);
  assign o_frame_done = frame_done_q;
  // Offers are bounded by the issued count, so surplus FIFO bytes wait for the next frame.
  assign o_spi_valid  = (state == XFER) && !fifo_empty && (issued < len_cap);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      len_rem      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      len_rem      <= len_rem_nxt;
      frame_done_q <= (state == HOLD) && (timer == '0);
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    len_rem_nxt = len_rem;
    case (state)
      IDLE: if (start_ok) begin
        state_nxt   = SETUP;
        timer_nxt   = TMR_W'(SS_SETUP_CYC - 1);
        len_rem_nxt = i_len;
      end
      SETUP: begin
        if (timer == '0) state_nxt = XFER;
        else             timer_nxt = timer - 1'b1;
      end
      XFER: if (i_spi_done) begin
        len_rem_nxt = len_rem - 1'b1;
        if (len_rem == LEN_WIDTH'(1)) begin
          state_nxt = HOLD;
          timer_nxt = TMR_W'(SS_HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (timer == '0) state_nxt = IDLE;
        else             timer_nxt = timer - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issued  <= '0;
      len_cap <= '0;
    end else if (start_ok) begin
      issued  <= '0;
      len_cap <= i_len;
    end else if (fifo_rd) begin
      issued  <= issued + 1'b1;
    end
  end

  // RX capture runs in every state; a done always lands in the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
    end else if (i_spi_done) begin
      o_rx_data  <= i_spi_rx_data;
      o_rx_valid <= 1'b1;
    end else if (i_rx_ready) begin
      o_rx_valid <= 1'b0;
    end
  end

`ifdef SPI_RX_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (reset)                                        o_rx_overrun <= 1'b0;
    else if (i_spi_done && o_rx_valid && !i_rx_ready) o_rx_overrun <= 1'b1;
    else if (start_ok)                                o_rx_overrun <= 1'b0;
  end
`endif

endmodule
